// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/words/CSUM frames from a byte stream into the program store,
// holding the CPU in reset until a frame completes with a matching XOR checksum.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         ADDR_WIDTH     = 8,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_HI, S_LO, S_CSUM, S_DONE, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            csum_q, csum_d;
  logic [7:0]            hi_q, hi_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  take;
  logic                  in_frame;

  assign take     = rx_valid && rx_ready_q;
  assign in_frame = (state_q == S_LEN) || (state_q == S_HI) ||
                    (state_q == S_LO)  || (state_q == S_CSUM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    csum_d     = csum_q;
    hi_d       = hi_q;
    to_d       = to_q;
    rx_ready_d = 1'b1;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;

    // An arriving byte always beats an expiring timeout.
    if (in_frame) begin
      if (take) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        state_d = S_ERR;
        error_d = 1'b1;
        done_d  = 1'b0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (take && rx_data == SYNC_BYTE) begin
          state_d    = S_LEN;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          to_d       = '0;
        end
      end
      S_LEN: begin
        if (take) begin
          cnt_d   = (rx_data == 8'd0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : CW'(rx_data);
          addr_d  = '0;
          csum_d  = 8'd0;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (take) begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (take) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {hi_q, rx_data};
          addr_d    = addr_q + 1'b1;
          csum_d    = csum_q ^ rx_data;
          cnt_d     = cnt_q - 1'b1;
          state_d   = (cnt_q == CW'(1)) ? S_CSUM : S_HI;
        end
      end
      S_CSUM: begin
        if (take) begin
          if (rx_data == csum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      csum_q     <= 8'd0;
      hi_q       <= 8'd0;
      to_q       <= '0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 16'd0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      csum_q     <= csum_d;
      hi_q       <= hi_d;
      to_q       <= to_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framing, checksum, full 256-word load, timeout, mid-frame reset.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [7:0]  log_a [0:511];
  logic [15:0] log_d [0:511];
  int          n_wr = 0;

  prog_loader #(.SYNC_BYTE(8'hA5), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Every cycle with wr_en high is logged, so a stuck strobe shows up as extra entries.
  always @(negedge clk) begin
    if (wr_en === 1'b1 && n_wr < 512) begin
      log_a[n_wr] = wr_addr;
      log_d[n_wr] = wr_data;
      n_wr = n_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int base;
    int bad;
    logic [7:0] cs;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_done", done, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rx_ready", rx_ready, 0);
    end
    rst = 1'b0;
    tick();
    chk("rel_rx_ready", rx_ready, 1);
    chk("rel_cpu_hold", cpu_hold, 1);
    chk("rel_done", done, 0);
    chk("rel_wr_en", wr_en, 0);

    // Good two-word frame
    base = n_wr;
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h40);
    chk("good_done", done, 1);
    chk("good_cpu_hold", cpu_hold, 0);
    chk("good_error", error, 0);
    idle(2);
    chk("good_nwr", n_wr - base, 2);
    chk("good_a0", log_a[base], 8'h00);
    chk("good_d0", log_d[base], 16'h1234);
    chk("good_a1", log_a[base+1], 8'h01);
    chk("good_d1", log_d[base+1], 16'hABCD);
    chk("good_addr_hold", wr_addr, 8'h01);
    chk("good_data_hold", wr_data, 16'hABCD);

    // Bad checksum; the sync byte re-holds the CPU on the same edge
    base = n_wr;
    send(8'hA5);
    chk("resync_cpu_hold", cpu_hold, 1);
    chk("resync_done", done, 0);
    send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h41);
    idle(2);
    chk("bad_error", error, 1);
    chk("bad_done", done, 0);
    chk("bad_cpu_hold", cpu_hold, 1);
    chk("bad_nwr", n_wr - base, 2);
    chk("bad_d1", log_d[base+1], 16'hABCD);

    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    send(8'h40);
    idle(1);
    chk("recover_error", error, 0);
    chk("recover_done", done, 1);

    // Junk bytes, then a 256-word frame (LEN=0) with data equal to address
    send(8'h00); send(8'hFF);
    chk("junk_done", done, 1);
    chk("junk_cpu_hold", cpu_hold, 0);
    base = n_wr;
    cs = 8'h00;
    send(8'hA5); send(8'h00);
    for (int w = 0; w < 256; w++) begin
      send(8'h00);
      send(w[7:0]);
      cs = cs ^ w[7:0];
    end
    send(cs);
    idle(2);
    chk("full_nwr", n_wr - base, 256);
    bad = 0;
    for (int w = 0; w < 256; w++) begin
      if (log_a[base+w] !== w[7:0] || log_d[base+w] !== {8'h00, w[7:0]}) bad++;
    end
    chk("full_map_mismatches", bad, 0);
    chk("full_done", done, 1);
    chk("full_cpu_hold", cpu_hold, 0);

    // Timeout: last byte, then 15 idle cycles keep going, the 16th expires
    base = n_wr;
    send(8'hA5); send(8'h01); send(8'h12);
    idle(15);
    chk("to_err_early", error, 0);
    idle(1);
    chk("to_error", error, 1);
    chk("to_done", done, 0);
    chk("to_cpu_hold", cpu_hold, 1);
    chk("to_nwr", n_wr - base, 0);

    // Reset after the first write of a three-word frame
    base = n_wr;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
    idle(1);
    chk("mid_nwr", n_wr - base, 1);
    chk("mid_d0", log_d[base], 16'h1122);
    rst = 1'b1;
    tick();
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_cpu_hold", cpu_hold, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    rst = 1'b0;
    tick();
    base = n_wr;
    send(8'hA5); send(8'h01); send(8'h56); send(8'h78); send(8'h2E);
    idle(2);
    chk("post_nwr", n_wr - base, 1);
    chk("post_a0", log_a[base], 8'h00);
    chk("post_d0", log_d[base], 16'h5678);
    chk("post_done", done, 1);
    chk("post_cpu_hold", cpu_hold, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting upstream of the CPU's instruction memory. It accepts a framed byte stream from the serial receiver, assembles 16-bit instruction words, and writes them sequentially into the 256-word program store read at `pc[7:0]`. While loading, it holds the CPU in reset. It releases the CPU only after a valid checksum.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `ADDR_WIDTH`, 8, program store address width (256 words)
- `TIMEOUT_CYCLES`, 1000000, maximum idle cycles between bytes inside a frame
- `clk`  in  1  single system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rx_valid`  in  1  byte available from serial receiver
- `rx_data`  in  8  received byte
- `rx_ready`  out  1  loader can accept a byte; a byte transfers when `rx_valid && rx_ready` at a rising edge
- `wr_en`  out  1  program-store write strobe, one cycle per word
- `wr_addr`  out  ADDR_WIDTH  word address
- `wr_data`  out  16  instruction word
- `cpu_hold`  out  1  high holds the CPU (and PC) in reset
- `done`  out  1  last frame loaded with a good checksum
- `error`  out  1  last frame failed (checksum or timeout)

## Operation
- Frame: `SYNC_BYTE`, `LEN`, then LEN words each sent high byte then low byte, then `CSUM`.
  - LEN = 1..255 words; LEN = 0 means 256.
  - CSUM = XOR of all payload bytes (both bytes of every word); sync and LEN are excluded.
- States and transitions:
  - IDLE: a byte equal to `SYNC_BYTE` → LEN_S; any other byte is discarded.
  - LEN_S: latch LEN into the word counter; clear `wr_addr` and the checksum accumulator → HI.
  - HI: store the high byte and XOR it into the checksum → LO.
  - LO: write `{hi, byte}` to `wr_addr`, XOR the byte into the checksum, decrement the counter; → HI if words remain, else → CSUM.
  - CSUM: byte == accumulator → DONE, else → ERR.
  - DONE: `done`=1, `cpu_hold`=0.
  - ERR: `error`=1, `cpu_hold`=1.
  - From DONE or ERR, a `SYNC_BYTE` starts a new frame: → LEN_S, and in the same edge `cpu_hold`=1, `done`=0, `error`=0. Other bytes are discarded.
- Timeout: in LEN_S, HI, LO or CSUM, a counter clears on every accepted byte. Reaching TIMEOUT_CYCLES with no byte → ERR.
- Address arithmetic:
  - `wr_addr` increments by 1 after each write.
  - A 256-word frame writes 0..255; the post-write increment wraps to 0 and is harmless.
  - Counter width is ADDR_WIDTH+1 so that LEN = 0 loads 256.
- A `SYNC_BYTE` value inside a frame is data. There is no resynchronisation mid-frame; recovery from a broken frame is by timeout only.
- `rx_ready` is 1 in every state after reset; the loader never back-pressures.

## Timing
- Reset values:
  - `rx_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0
  - `cpu_hold`=1, `done`=0, `error`=0
  - state IDLE
- `rx_ready` goes to 1 on the first edge with `rst` low.
- `wr_en`, `wr_addr` and `wr_data` are registered:
  - Valid in the cycle after the LO-byte edge.
  - `wr_en` is high for exactly one cycle.
  - `wr_addr` and `wr_data` hold until the next write.
- `done`/`cpu_hold` change in the cycle after the CSUM-byte edge. The final word's write strobe therefore precedes or coincides with the CPU release, never follows it.
- Back-to-back bytes (`rx_valid` high every cycle) are accepted at one per cycle with no lost bytes.
- `rst` asserted mid-frame:
  - Next edge returns to reset values.
  - Partially written words remain in the store.
  - The CPU stays held.
- A timeout and a byte arriving on the same edge: the byte wins and the counter clears.

## Test plan
- Reset release: `rst` high 3 cycles, then low → `cpu_hold`=1, `done`=0, `wr_en`=0 throughout; `rx_ready`=1 one cycle after release.
- Good frame: A5, 02, 12, 34, AB, CD, CSUM=12^34^AB^CD=40 → writes addr0=0x1234 and addr1=0xABCD (one-cycle `wr_en` each), then `done`=1, `cpu_hold`=0.
- Bad checksum: same frame with CSUM=41 → both words written, `error`=1, `done`=0, `cpu_hold`=1. A following good frame gives `error`=0 and `done`=1.
- Full frame: A5, 00, then 256 words with data=addr, then correct CSUM → 256 writes at addresses 0..255, `done`=1; junk bytes 00, FF sent before the A5 are ignored.
- Timeout: with TIMEOUT_CYCLES=16, send A5, 01, 12, then stall 16 cycles → `error`=1, no write issued.
- Reset mid-frame: send A5, 03, 11, 22, assert `rst` after the write of 0x1122 → outputs return to reset values; a new good frame loads correctly from addr 0.
